// File: rtl/sha_msg_padder_if.sv
// Byte-stream in / padded-block out bundle for sha_msg_padder.
// SHA_PAD_LAST_FLAG_EN adds block_last (set on the block that carries the length field).
interface sha_msg_padder_if;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         msg_end;
  logic         byte_ready;
  logic [511:0] data_block;
  logic         block_valid;
  logic         block_start;
  logic         block_ack;
`ifdef SHA_PAD_LAST_FLAG_EN
  logic         block_last;
`endif

  modport master (
    output byte_in, byte_valid, msg_end, block_ack,
`ifdef SHA_PAD_LAST_FLAG_EN
    input  block_last,
`endif
    input  byte_ready, data_block, block_valid, block_start
  );

  modport slave (
    input  byte_in, byte_valid, msg_end, block_ack,
`ifdef SHA_PAD_LAST_FLAG_EN
    output block_last,
`endif
    output byte_ready, data_block, block_valid, block_start
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs a byte stream into padded 512-bit blocks, one at a time.
// Optional feature macro: SHA_PAD_LAST_FLAG_EN (drives block_last).
module sha_msg_padder #(
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  sha_msg_padder_if.slave  bus
);

  typedef enum logic [1:0] {StFill, StEmit, StPad} state_e;

  state_e             state_q, state_d;
  logic [511:0]       buf_q, buf_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               end_pend_q, end_pend_d;
  logic               len_pend_q, len_pend_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               start_q, start_d;
  logic               last_q, last_d;
  logic [63:0]        len;
  logic [8:0]         pos;
  logic               ack;

  assign len = 64'({cnt_q, 3'b000});
  // MSB of byte idx: 511 - 8*idx
  assign pos = {~idx_q, 3'b111};
  // The core cannot complete in its start cycle; ignoring ack there keeps block_start from
  // pulsing back-to-back on the extra-length block.
  assign ack = bus.block_ack && valid_q && !start_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    end_pend_d = end_pend_q;
    len_pend_d = len_pend_q;
    last_d     = last_q;

    case (state_q)
      StFill: begin
        if (ready_q) begin
          if (bus.byte_valid) begin
            buf_d[pos -: 8] = bus.byte_in;
            idx_d           = idx_q + 6'd1;
            cnt_d           = cnt_q + CNT_W'(1);
          end
          if (bus.byte_valid && idx_q == 6'd63) begin
            state_d    = StEmit;
            end_pend_d = bus.msg_end;
          end else if (bus.msg_end) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        buf_d[pos -: 8] = 8'h80;
        if (idx_q <= 6'd55) begin
          buf_d[63:0] = len;
          cnt_d       = '0;
          last_d      = 1'b1;
        end else begin
          len_pend_d = 1'b1;
        end
        state_d = StEmit;
      end
      StEmit: begin
        if (ack) begin
          buf_d  = '0;
          idx_d  = '0;
          last_d = 1'b0;
          if (end_pend_q) begin
            end_pend_d = 1'b0;
            state_d    = StPad;
          end else if (len_pend_q) begin
            buf_d[63:0] = len;
            len_pend_d  = 1'b0;
            cnt_d       = '0;
            last_d      = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase

    ready_d = (state_d == StFill);
    valid_d = (state_d == StEmit);
    start_d = (state_d == StEmit) && ((state_q != StEmit) || ack);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFill;
      buf_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      end_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      end_pend_q <= end_pend_d;
      len_pend_q <= len_pend_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      last_q     <= last_d;
    end
  end

  assign bus.byte_ready  = ready_q;
  assign bus.data_block  = buf_q;
  assign bus.block_valid = valid_q;
  assign bus.block_start = start_q;

`ifdef SHA_PAD_LAST_FLAG_EN
  assign bus.block_last = last_q;
`else
  logic unused_last;
  assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: a FIPS 180-4 padding model queues expected blocks, a negedge
// monitor checks every emitted block, and directed steps pin timing and literal values.
module tb_sha_msg_padder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha_msg_padder_if bus ();
  sha_msg_padder #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int n_start = 0;
  logic [511:0] exp_q[$];
  logic         exp_last_q[$];
  logic [511:0] cur = '0;
  logic         cur_last = 1'b0;
  logic         prev_start = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Padded message = msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  function automatic void enqueue(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  l;
    logic [511:0] blk;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    l = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(l[i*8 +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == p.size() / 64 - 1);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.block_start) begin
      n_start++;
      if (exp_q.size() == 0) begin
        chk("unexpected_block", bus.data_block, '0);
        cur = bus.data_block;
      end else begin
        cur      = exp_q.pop_front();
        cur_last = exp_last_q.pop_front();
      end
      chk("start_back_to_back", 512'(prev_start), 512'(0));
    end
    if (bus.block_valid) begin
      chk("block_data", bus.data_block, cur);
`ifdef SHA_PAD_LAST_FLAG_EN
      chk("block_last", 512'(bus.block_last), 512'(cur_last));
`endif
    end
    prev_start = bus.block_start;
  end

  task automatic push(input logic [7:0] b, input logic e, input logic v);
    int t = 0;
    bus.byte_in = b; bus.byte_valid = v; bus.msg_end = e;
    while (!bus.byte_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("push_timeout", 512'(t), 512'(0));
    @(negedge clk);
    bus.byte_valid = 1'b0; bus.msg_end = 1'b0;
  endtask

  task automatic send(input logic [7:0] m[$], input logic with_end);
    for (int i = 0; i < m.size(); i++) push(m[i], with_end && (i == m.size() - 1), 1'b1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.block_valid && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("valid_timeout", 512'(t), 512'(0));
  endtask

  task automatic ack_block(input int delay);
    @(negedge clk);
    repeat (delay) @(negedge clk);
    bus.block_ack = 1'b1;
    @(negedge clk);
    bus.block_ack = 1'b0;
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_ready"}, 512'(bus.byte_ready), 512'(0));
    chk({name, "_valid"}, 512'(bus.block_valid), 512'(0));
    chk({name, "_start"}, 512'(bus.block_start), 512'(0));
    chk({name, "_data"}, bus.data_block, '0);
  endtask

  initial begin
    logic [7:0]   m[$];
    logic [511:0] abc_blk, snap;
    int           s0;
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[63:0]    = 64'h18;

    reset = 1'b0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.msg_end = 1'b0; bus.block_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 512'(bus.byte_ready), 512'(1));

    // "abc"; also pin the model against the literal block
    m = '{8'h61, 8'h62, 8'h63};
    enqueue(m);
    chk("model_abc", exp_q[exp_q.size()-1], abc_blk);
    s0 = n_start;
    send(m, 1'b1);
    chk("abc_pad_cycle_valid", 512'(bus.block_valid), 512'(0));
    @(negedge clk);
    chk("abc_valid_after_pad", 512'(bus.block_valid), 512'(1));
    chk("abc_literal", bus.data_block, abc_blk);
    ack_block(3);
    chk("abc_valid_drop", 512'(bus.block_valid), 512'(0));
    chk("abc_ready_back", 512'(bus.byte_ready), 512'(1));
    chk("abc_start_count", 512'(n_start - s0), 512'(1));

    // Empty message
    m = {};
    enqueue(m);
    s0 = n_start;
    push(8'h00, 1'b1, 1'b0);
    wait_valid();
    chk("empty_literal", bus.data_block, {8'h80, 504'd0});
    ack_block(1);
    chk("empty_start_count", 512'(n_start - s0), 512'(1));

    // 56 zero bytes: marker block then length-only block, valid held across the ack
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'h00);
    enqueue(m);
    chk("model_56_count", 512'(exp_q.size()), 512'(2));
    send(m, 1'b1);
    wait_valid();
    chk("z56_blk1_marker", 512'(bus.data_block[63:56]), 512'(8'h80));
    ack_block(2);
    chk("z56_valid_held", 512'(bus.block_valid), 512'(1));
    chk("z56_start_again", 512'(bus.block_start), 512'(1));
    chk("z56_literal_len", bus.data_block, 512'(64'h1C0));
    ack_block(0);
    chk("z56_ready_back", 512'(bus.byte_ready), 512'(1));

    // 64 x 0xFF with msg_end on the last byte
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'hFF);
    enqueue(m);
    send(m, 1'b1);
    chk("ff_valid_at_64", 512'(bus.block_valid), 512'(1));
    chk("ff_ready_low", 512'(bus.byte_ready), 512'(0));
    chk("ff_blk1_literal", bus.data_block, {512{1'b1}});
    ack_block(2);
    chk("ff_valid_gap", 512'(bus.block_valid), 512'(0));
    @(negedge clk);
    chk("ff_blk2_literal", bus.data_block, {8'h80, 440'd0, 64'h200});
    ack_block(1);

    // Delayed ack with bytes offered meanwhile
    m = '{8'h01, 8'h02, 8'h03};
    enqueue(m);
    s0 = n_start;
    send(m, 1'b1);
    wait_valid();
    snap = bus.data_block;
    bus.byte_in = 8'hAA; bus.byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_ready_low", 512'(bus.byte_ready), 512'(0));
      chk("hold_data_stable", bus.data_block, snap);
    end
    bus.byte_valid = 1'b0;
    bus.block_ack = 1'b1;
    @(negedge clk);
    bus.block_ack = 1'b0;
    chk("hold_valid_drop", 512'(bus.block_valid), 512'(0));
    chk("hold_ready_back", 512'(bus.byte_ready), 512'(1));
    chk("hold_start_once", 512'(n_start - s0), 512'(1));

    // Reset after 20 bytes, then "abc" must come out clean
    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'h55);
    send(m, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_zero("midreset");
    reset = 1'b1;
    @(negedge clk);
    m = '{8'h61, 8'h62, 8'h63};
    enqueue(m);
    send(m, 1'b1);
    wait_valid();
    chk("abc_after_reset", bus.data_block, abc_blk);
    ack_block(1);

    repeat (3) @(negedge clk);
    chk("blocks_drained", 512'(exp_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sha_msg_padder.md
# sha_msg_padder

Upstream stage of the SHA-256 core: accepts a message as a byte stream (from the UART receive path) and emits FIPS 180-4 padded 512-bit blocks on `data_block`, one at a time. It appends the 0x80 marker, zero fill and the 64-bit big-endian bit-length, inserting an extra block when required. It holds each block until the core reports completion.

## Interface
- `CNT_W`, default 32: width of the message byte counter, legal range 8..61.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `byte_in`  in  8  message byte.
- `byte_valid`  in  1  `byte_in` valid.
- `msg_end`  in  1  end-of-message strobe; may coincide with `byte_valid`, in which case that byte is the last byte.
- `byte_ready`  out  1  the block accepts `byte_valid` and `msg_end` this cycle.
- `data_block`  out  512  current block; byte i occupies bits [511-8i -: 8].
- `block_valid`  out  1  `data_block` holds a complete block.
- `block_start`  out  1  one-cycle pulse on the first `block_valid` cycle; drives the core's `start`.
- `block_ack`  in  1  core `complete`; releases the current block.

## Operation
- States: FILL, EMIT, PAD.
- Reset state is FILL. Buffer `data_block`, byte index `idx` (0..63), byte count `cnt`, and `end_pend` are all cleared.
- **FILL**
  - An accepted byte (`byte_valid && byte_ready`) is written at `idx`, then `idx++` and `cnt++`.
  - If that byte makes `idx` reach 64: go to EMIT. If `msg_end` is also set, set `end_pend`.
  - `msg_end` accepted with `idx` < 64 after any byte write: go to PAD.
- **PAD**
  - Write 0x80 at `idx`.
  - If `idx` ≤ 55: write length L = {cnt, 3'b000}, zero-extended to 64 bits, into bits [63:0], and clear `cnt` as the message completes.
  - Otherwise set `len_pend`.
  - Go to EMIT.
- **EMIT**
  - `block_valid` = 1.
  - On `block_ack`: clear the buffer and set `idx` = 0.
  - Next state:
    - `end_pend` set → PAD with `idx` = 0, clear `end_pend`.
    - `len_pend` set → write L at [63:0] into the cleared buffer, clear `len_pend` and `cnt`, stay in EMIT.
    - Otherwise → FILL.
- Padding by message length mod 64:
  - 0..55: one padded block.
  - 56..63: a marker block, then a zero-plus-length block.
  - Exactly 0 mod 64 with a nonzero length: a full data block, then a 0x80-plus-length block.
- Empty message (`msg_end` with `idx` = 0, `cnt` = 0): one block of 0x80 followed by zeros, length 0.
- `cnt` wraps modulo 2^CNT_W. The length field reflects the wrapped count.
- `byte_valid` or `msg_end` while `byte_ready` = 0: ignored. The producer must hold them.
- `block_ack` while `block_valid` = 0: ignored.
- Reset mid-message or mid-EMIT: partial data is discarded and all state returns to reset values.

## Timing
- All outputs are registered.
- Values while `reset` = 0: `byte_ready` 0, `block_valid` 0, `block_start` 0, `data_block` 0. `byte_ready` rises on the first edge after reset release.
- `byte_ready` = (state == FILL); at most one byte is accepted per cycle.
- 64th byte accepted at edge k: `block_valid` and `block_start` high after k. `byte_ready` low after k.
- `msg_end` accepted at edge k: PAD during k..k+1, `block_valid` high after k+1.
- `block_ack` sampled at edge m:
  - `block_valid` low after m when returning to FILL.
  - `byte_ready` high after m.
- Extra-length block (the `len_pend` case): `block_valid` drops for 0 cycles, with `block_start` pulsing again after m.
- Extra 0x80 block (the `end_pend` case): `block_valid` drops for 1 cycle.
- `block_start` is never high on two consecutive cycles.

## Configuration
- `SHA_PAD_LAST_FLAG_EN`
  - Defined: adds output `block_last` (1 bit, reset 0), valid while `block_valid` and high on the block carrying the length field.
  - Undefined: the port and its logic are absent; the remaining behaviour is identical.

## Test plan
- "abc" (0x61,0x62,0x63, `msg_end` with 0x63) → single block 0x61626380 followed by zeros, with [63:0] = 0x18. Fed to the core, this block must yield ba7816bf…f20015ad.
- Empty message (`msg_end` alone) → single block 0x80 followed by zeros, [63:0] = 0. `block_start` pulses once.
- 56 bytes of 0x00 → block 1: bytes 0..55 = 0, byte 56 = 0x80, rest 0. Block 2: all zero except [63:0] = 0x1C0. `block_valid` held continuously across the ack.
- 64 bytes of 0xFF, `msg_end` with the 64th byte → block 1 all 0xFF. Block 2: byte 0 = 0x80, [63:0] = 0x200.
- Ack delayed 10 cycles → `byte_ready` stays 0 for those cycles. Bytes offered meanwhile are ignored, `data_block` stays stable, and `block_start` pulses exactly once.
- `reset` = 0 after 20 bytes → all outputs go to 0. A following "abc" message produces the "abc" block exactly, with no residue from the discarded bytes.
